// File: rtl/exa_crosb_vc_demux.sv
// exa_crosb_vc_demux: packet-locked, VC-aware crossbar demux with a 2-entry skid buffer
// Ports: ACLK/ARESETN (async active-low) clock/reset; DATA_i/VALID_i/LAST_i/PRIO_i/VC_i/SEL_i
// upstream beat (VC_i/SEL_i sampled on head beats); READY_o registered upstream ready;
// DATA_o/VALID_o/LAST_o/PRIO_o/VC_o per-output beat; READY_i per-output ready; ERR_o illegal-select pulse.
// Optional: EXA_CROSB_DEMUX_SEL_CHECK_EN drops packets whose head select is out of range.
module exa_crosb_vc_demux #(
  parameter int data_width = 128,
  parameter int output_num = 16,
  parameter int vc_num     = 2,
  parameter int sel_width  = $clog2(output_num),
  parameter int vc_width   = (vc_num > 1) ? $clog2(vc_num) : 1
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [data_width-1:0] DATA_i,
  input  logic                  VALID_i,
  input  logic                  LAST_i,
  input  logic                  PRIO_i,
  input  logic [vc_width-1:0]   VC_i,
  input  logic [sel_width-1:0]  SEL_i,
  output logic                  READY_o,
  output logic [data_width-1:0] DATA_o [output_num],
  output logic [output_num-1:0] VALID_o,
  output logic [output_num-1:0] LAST_o,
  output logic [output_num-1:0] PRIO_o,
  output logic [vc_width-1:0]   VC_o [output_num],
  input  logic [output_num-1:0] READY_i,
  output logic                  ERR_o
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t r_state, w_state_nxt;
  logic [sel_width-1:0]  r_lock_sel, w_sel;
  logic [vc_width-1:0]   r_lock_vc, w_vc;
  logic [data_width-1:0] r_data [2];
  logic [1:0]            r_last, r_prio;
  logic [vc_width-1:0]   r_vc [2];
  logic [sel_width-1:0]  r_sel [2];
  logic                  r_rd, r_wr;
  logic [1:0]            r_cnt, w_cnt_nxt;
  logic                  w_acc, w_head, w_drop, w_push, w_pop, w_any;

  assign w_acc  = VALID_i & READY_o;
  assign w_head = r_state == IDLE;
  assign w_sel  = w_head ? SEL_i : r_lock_sel;
  assign w_vc   = w_head ? VC_i : r_lock_vc;

`ifdef EXA_CROSB_DEMUX_SEL_CHECK_EN
  logic r_drop, r_err, w_bad;
  assign w_bad  = {1'b0, SEL_i} >= (sel_width + 1)'(output_num);
  // the drop decision is made on the head beat and held for the rest of the packet
  assign w_drop = w_head ? w_bad : r_drop;
  assign ERR_o  = r_err;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_drop <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_acc & w_head & w_bad;
      if (w_acc & w_head) r_drop <= w_bad;
    end
  end
`else
  assign w_drop = 1'b0;
  assign ERR_o  = 1'b0;
`endif

  assign w_push    = w_acc & ~w_drop;
  assign w_any     = r_cnt != 2'd0;
  assign w_pop     = w_any & READY_i[r_sel[r_rd]];
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    w_state_nxt = w_acc ? (LAST_i ? IDLE : LOCKED) : r_state;
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state    <= IDLE;
      r_lock_sel <= '0;
      r_lock_vc  <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_cnt      <= 2'd0;
      READY_o    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_acc & w_head) begin
        r_lock_sel <= SEL_i;
        r_lock_vc  <= VC_i;
      end
      if (w_push) r_wr <= ~r_wr;
      if (w_pop) r_rd <= ~r_rd;
      r_cnt   <= w_cnt_nxt;
      READY_o <= w_cnt_nxt < 2'd2;
    end
  end

  // payload storage needs no reset: it is only visible while r_cnt marks it valid
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_data[r_wr] <= DATA_i;
      r_last[r_wr] <= LAST_i;
      r_prio[r_wr] <= PRIO_i;
      r_vc[r_wr]   <= w_vc;
      r_sel[r_wr]  <= w_sel;
    end
  end

  genvar i;
  for (i = 0; i < output_num; i++) begin : g_out
    logic w_hit;
    assign w_hit      = w_any && (r_sel[r_rd] == sel_width'(i));
    assign VALID_o[i] = w_hit;
    assign LAST_o[i]  = w_hit & r_last[r_rd];
    assign PRIO_o[i]  = w_hit & r_prio[r_rd];
    assign DATA_o[i]  = w_hit ? r_data[r_rd] : '0;
    assign VC_o[i]    = w_hit ? r_vc[r_rd] : '0;
  end
endmodule

// File: doc/exa_crosb_vc_demux.md
# exa_crosb_vc_demux

Registered, packet-locked, virtual-channel-aware crossbar demultiplexer for the Exanet switch. It sits between an input port's arbiter stage and the crossbar output multiplexers. It steers whole packets, not single beats, to one of `output_num` outputs, and carries the VC tag with each packet. A 2-entry skid buffer decouples upstream ready from downstream ready, and per-output valid/ready backpressure is supported.

## Interface
- `data_width`, 128, beat payload width
- `output_num`, 16, number of crossbar outputs (need not be a power of two)
- `vc_num`, 2, number of virtual channels
- `sel_width`, `log2(output_num)`, output select width
- `vc_width`, `log2(vc_num)` (minimum 1), VC tag width

Ports:
- `ACLK` in 1: clock
- `ARESETN` in 1: reset, asynchronous, active-low
- `DATA_i` in `data_width`: beat payload
- `VALID_i` in 1: beat valid
- `LAST_i` in 1: last beat of packet
- `PRIO_i` in 1: per-beat priority flag
- `VC_i` in `vc_width`: VC of packet, sampled on head beat only
- `SEL_i` in `sel_width`: destination output, sampled on head beat only
- `READY_o` out 1: upstream ready, driven from a register
- `DATA_o[output_num]` out `data_width` each: per-output payload
- `VALID_o` out `output_num`: per-output valid
- `LAST_o` out `output_num`: per-output last
- `PRIO_o` out `output_num`: per-output priority
- `VC_o[output_num]` out `vc_width` each: per-output VC tag
- `READY_i` in `output_num`: per-output downstream ready
- `ERR_o` out 1: illegal-select pulse (see Configuration)

## Operation
- **Upstream accept.** A beat is accepted when `VALID_i & READY_o`.
- **Lock FSM.** States are IDLE and LOCKED.
  - IDLE: an accepted beat is a head beat. `SEL_i` and `VC_i` are latched into `lock_sel`/`lock_vc`. If `LAST_i=0` the FSM goes to LOCKED. If `LAST_i=1` (single-beat packet) it stays IDLE.
  - LOCKED: accepted beats use `lock_sel`/`lock_vc`, and `SEL_i`/`VC_i` are ignored. An accepted beat with `LAST_i=1` returns the FSM to IDLE.
  - `VALID_i=0` inside a packet leaves the FSM state unchanged.
- **Skid buffer.** 2 entries in FIFO order. Each entry holds {data, last, prio, vc, sel}. The entry's sel/vc come from the head-beat value or the locked value, per the Lock FSM.
- **Output drive.**
  - When the buffer is non-empty, the head entry drives only output `s = head.sel`: `VALID_o[s]=1`, `DATA_o[s]`, `LAST_o[s]`, `PRIO_o[s]`, `VC_o[s]` come from the head entry.
  - All other outputs drive 0 on every field. With an empty buffer, all outputs drive 0.
- **Pop.** The head entry pops when `READY_i[head.sel]=1`. `READY_i` of non-selected outputs is ignored.
- **Simultaneous push and pop.** Allowed in the same cycle; the count is unchanged.
- **READY_o update.** `READY_o` is registered. Its next value is 1 iff the next buffer count is below 2.
  - Count 1 with push and pop: `READY_o` stays 1, full throughput.
  - Count 1 with push and no pop: `READY_o` goes to 0 next cycle, count 2.
  - Count 2: no push is possible.
- **Beat order.** Beats of one packet exit in order on one output. Packets never interleave.

## Timing
- **Latency.** A beat accepted at clock edge N is visible on its output after edge N (registered). No combinational path exists from inputs to outputs.
- **No ready feedthrough.** There is no combinational path from `READY_i` to `READY_o`.
- **Reset values.**
  - During reset (`ARESETN=0`), asynchronously: `READY_o=0`, every output `VALID_o`/`LAST_o`/`PRIO_o`=0, `DATA_o`/`VC_o`=0, `ERR_o=0`, FSM=IDLE, buffer count=0.
  - `READY_o` rises at the first `ACLK` edge after reset release.
- **Reset mid-packet.** Buffered beats are discarded. After release the next accepted beat is treated as a head beat.

## Configuration
- **Macro:** `EXA_CROSB_DEMUX_SEL_CHECK_EN`.
- **Defined:**
  - A head beat with `SEL_i >= output_num` is accepted and its whole packet is dropped (not pushed).
  - The FSM still tracks `LAST_i`.
  - `ERR_o` pulses high for one cycle, on the cycle after the offending head beat is accepted.
- **Undefined:**
  - Check and drop logic are absent, and `ERR_o` is tied 0.
  - `SEL_i` must be `< output_num`. An illegal select is unsupported: the entry is never popped and the block stalls.

## Test plan
- **Single-beat packets.** Single-beat packets to outputs 0, 5, 15, with all `READY_i=1` and back-to-back valids. Required: each appears on the chosen output one cycle after acceptance, all other outputs stay 0, and `READY_o` stays 1 throughout.
- **Packet lock.** A 4-beat packet with `SEL_i=3` on beat 0, then `SEL_i` changed to 7 and `VC_i` changed on beats 1–3. Required: all 4 beats are on output 3 with the head VC tag, and output 7 stays idle.
- **Backpressure.** Hold `READY_i[2]=0` during a packet to output 2. Required: after two accepts `READY_o=0` and `VALID_o[2]` is held with stable data. Releasing `READY_i[2]` drains the beats in order, and `READY_o` returns to 1 one cycle after the first pop.
- **Ignored ready.** Drive `READY_i[9]=1` only while the head beat targets output 4. Required: no pop, and the buffer stays full.
- **Reset mid-packet.** Assert `ARESETN=0` after beat 2 of a 5-beat packet. Required: all outputs and `READY_o` are 0 immediately. After release, a new beat with `SEL_i=1` and `LAST_i=1` is routed to output 1.
- **Illegal select.** With `output_num=12` and the macro defined, send a head beat with `SEL_i=13` in a 3-beat packet. Required: no output valid, `ERR_o` high for exactly one cycle, and the following packet is routed normally.
